// File: rtl/rv2t_pipeline_controller_if.sv
// Handshake and status bundle between the RV2T core datapath and its pipeline controller.
interface rv2t_pipeline_controller_if;
    localparam int unsigned INSTRET_W = 32;
    localparam int unsigned STATE_W   = 3;

    logic                 sync_reset;
    logic                 start;
    logic                 fetch_done;
    logic                 ctl_LOAD;
    logic                 ctl_STORE;
    logic                 ctl_MUL_DIV_FUNCT3;
    logic                 ctl_WFI;
    logic                 mem_done;
    logic                 mul_div_done;
    logic                 exception;
    logic                 interrupt_pending;

    logic                 fetch_enable;
    logic                 decode_enable;
    logic                 exe_enable;
    logic                 mem_enable;
    logic                 mul_div_enable;
    logic                 wb_enable;
    logic                 trap_enter;
    logic                 core_sleep;
    logic [INSTRET_W-1:0] instret;
    logic [STATE_W-1:0]   state_out;

    // Datapath side: issues completions and decoded flags, consumes stage pulses.
    modport master (
        output sync_reset, start, fetch_done,
        output ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI,
        output mem_done, mul_div_done, exception, interrupt_pending,
        input  fetch_enable, decode_enable, exe_enable, mem_enable,
        input  mul_div_enable, wb_enable, trap_enter, core_sleep,
        input  instret, state_out
    );

    // Controller side.
    modport slave (
        input  sync_reset, start, fetch_done,
        input  ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI,
        input  mem_done, mul_div_done, exception, interrupt_pending,
        output fetch_enable, decode_enable, exe_enable, mem_enable,
        output mul_div_enable, wb_enable, trap_enter, core_sleep,
        output instret, state_out
    );
endinterface

// File: rtl/rv2t_pipeline_controller.sv
// Multi-cycle RV2T pipeline sequencer: walks each instruction through FETCH..WB,
// handles memory/mul-div stalls, traps, WFI sleep and the retired-instruction counter.
module rv2t_pipeline_controller (
    input  logic                          clk,
    input  logic                          reset,
    rv2t_pipeline_controller_if.slave     bus
);
    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        MULDIV = 3'd5,
        WB     = 3'd6,
        TRAP   = 3'd7
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   sleep_q;
    logic                   sleep_d;

    logic                   fetch_en_q;
    logic                   decode_en_q;
    logic                   exe_en_q;
    logic                   mem_en_q;
    logic                   mul_div_en_q;
    logic                   wb_en_q;
    logic                   trap_q;
    logic                   core_sleep_q;
    logic [INSTRET_W-1:0]   instret_q;

    logic                   fetch_en_c;
    logic                   decode_en_c;
    logic                   exe_en_c;
    logic                   mem_en_c;
    logic                   mul_div_en_c;
    logic                   wb_en_c;
    logic                   trap_c;
    logic                   core_sleep_c;

    // State and sleep-flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sleep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sleep_q <= sleep_d;
        end
    end

    // Next-state selection; sync_reset overrides everything.
    always_comb begin
        state_d = state_q;
        sleep_d = sleep_q;
        if (bus.sync_reset) begin
            state_d = IDLE;
            sleep_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) state_d = FETCH;
                end
                FETCH: begin
                    if (bus.fetch_done) state_d = DECODE;
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    sleep_d = 1'b0;
                    if (bus.exception) begin
                        state_d = TRAP;
                    end else if (bus.ctl_LOAD || bus.ctl_STORE) begin
                        state_d = MEM;
                    end else if (bus.ctl_MUL_DIV_FUNCT3) begin
                        state_d = MULDIV;
                    end else if (bus.ctl_WFI) begin
                        state_d = WB;
                        sleep_d = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    // A fault reported together with mem_done still wins.
                    if (bus.exception)     state_d = TRAP;
                    else if (bus.mem_done) state_d = WB;
                end
                MULDIV: begin
                    if (bus.mul_div_done) state_d = WB;
                end
                WB: begin
                    if (bus.interrupt_pending) begin
                        state_d = TRAP;
                        sleep_d = 1'b0;
                    end else if (!sleep_q) begin
                        state_d = FETCH;
                    end
                end
                TRAP: begin
                    state_d = FETCH;
                    sleep_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    sleep_d = 1'b0;
                end
            endcase
        end
    end

    // Pulses are looked ahead from the transition so they land registered on the entry cycle.
    always_comb begin
        fetch_en_c   = (state_d == FETCH)  && (state_q != FETCH);
        decode_en_c  = (state_d == DECODE);
        exe_en_c     = (state_d == EXEC);
        mem_en_c     = (state_d == MEM)    && (state_q != MEM);
        mul_div_en_c = (state_d == MULDIV) && (state_q != MULDIV);
        wb_en_c      = (state_d == WB)     && (state_q != WB);
        trap_c       = (state_d == TRAP);
        core_sleep_c = (state_d == WB)     && (state_q == WB) && sleep_q;
    end

    // Registered outputs and retirement counter; sync_reset leaves instret alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_en_q   <= 1'b0;
            decode_en_q  <= 1'b0;
            exe_en_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mul_div_en_q <= 1'b0;
            wb_en_q      <= 1'b0;
            trap_q       <= 1'b0;
            core_sleep_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            fetch_en_q   <= fetch_en_c;
            decode_en_q  <= decode_en_c;
            exe_en_q     <= exe_en_c;
            mem_en_q     <= mem_en_c;
            mul_div_en_q <= mul_div_en_c;
            wb_en_q      <= wb_en_c;
            trap_q       <= trap_c;
            core_sleep_q <= core_sleep_c;
            instret_q    <= instret_q + INSTRET_W'(wb_en_c);
        end
    end

    assign bus.fetch_enable   = fetch_en_q;
    assign bus.decode_enable  = decode_en_q;
    assign bus.exe_enable     = exe_en_q;
    assign bus.mem_enable     = mem_en_q;
    assign bus.mul_div_enable = mul_div_en_q;
    assign bus.wb_enable      = wb_en_q;
    assign bus.trap_enter     = trap_q;
    assign bus.core_sleep     = core_sleep_q;
    assign bus.instret        = instret_q;
    assign bus.state_out      = state_q;

endmodule

// File: tb/tb_rv2t_pipeline_controller.sv
// Bench for rv2t_pipeline_controller: instruction-level reference model driving random
// and directed instruction streams, checking per-cycle stage, pulses, sleep and instret.
module tb_rv2t_pipeline_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv2t_pipeline_controller_if bus ();
    rv2t_pipeline_controller dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_MULDIV = 3'd5, S_WB = 3'd6, S_TRAP = 3'd7;
    // Pulse vector order: fetch, decode, exe, mem, mul_div, wb, trap.
    localparam logic [6:0] P_NONE = 7'b0000000, P_F = 7'b1000000, P_D = 7'b0100000,
                           P_E = 7'b0010000, P_M = 7'b0001000, P_X = 7'b0000100,
                           P_W = 7'b0000010, P_T = 7'b0000001;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_MULDIV = 3, K_WFI = 4, K_EXC = 5;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_instret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pulses();
        return {bus.fetch_enable, bus.decode_enable, bus.exe_enable, bus.mem_enable,
                bus.mul_div_enable, bus.wb_enable, bus.trap_enter};
    endfunction

    // Check the current cycle's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] p, input logic slp);
        chk({tag, ":state"},   32'(bus.state_out),  32'(st));
        chk({tag, ":pulses"},  32'(pulses()),       32'(p));
        chk({tag, ":sleep"},   32'(bus.core_sleep), 32'(slp));
        chk({tag, ":instret"}, bus.instret,         model_instret);
        @(posedge clk);
        #1;
    endtask

    // Randomize every input the current state does not care about.
    task automatic noise();
        bus.sync_reset         = 1'b0;
        bus.start              = 1'($urandom);
        bus.fetch_done         = 1'($urandom);
        bus.ctl_LOAD           = 1'($urandom);
        bus.ctl_STORE          = 1'($urandom);
        bus.ctl_MUL_DIV_FUNCT3 = 1'($urandom);
        bus.ctl_WFI            = 1'($urandom);
        bus.mem_done           = 1'($urandom);
        bus.mul_div_done       = 1'($urandom);
        bus.exception          = 1'b0;
        bus.interrupt_pending  = 1'($urandom);
    endtask

    task automatic leave_idle();
        noise(); bus.start = 1'b0; cyc("idle", S_IDLE, P_NONE, 1'b0);
        noise(); bus.start = 1'b1; cyc("idle_start", S_IDLE, P_NONE, 1'b0);
    endtask

    // One instruction from its first FETCH cycle until the controller is back in FETCH.
    task automatic run_instr(input int kind, input int fw, input int lat, input bit irq_after,
                             input bit exc_mem);
        for (int i = 0; i <= fw; i++) begin
            noise(); bus.fetch_done = (i == fw);
            cyc("fetch", S_FETCH, (i == 0) ? P_F : P_NONE, 1'b0);
        end
        noise(); cyc("decode", S_DECODE, P_D, 1'b0);
        noise();
        bus.exception          = (kind == K_EXC);
        bus.ctl_LOAD           = (kind == K_LOAD)  || ((kind == K_STORE || kind == K_EXC) && 1'($urandom));
        bus.ctl_STORE          = (kind == K_STORE) || ((kind == K_LOAD  || kind == K_EXC) && 1'($urandom));
        bus.ctl_MUL_DIV_FUNCT3 = (kind == K_MULDIV) ||
                                 ((kind == K_LOAD || kind == K_STORE || kind == K_EXC) && 1'($urandom));
        bus.ctl_WFI            = (kind == K_WFI) || ((kind != K_ALU) && 1'($urandom));
        cyc("exec", S_EXEC, P_E, 1'b0);
        if (kind == K_EXC) begin
            noise(); cyc("trap_exec", S_TRAP, P_T, 1'b0);
            return;
        end
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int i = 0; i < lat; i++) begin
                noise();
                bus.mem_done  = (i == lat - 1);
                bus.exception = exc_mem && (i == lat - 1);
                cyc("mem", S_MEM, (i == 0) ? P_M : P_NONE, 1'b0);
            end
            if (exc_mem) begin
                noise(); cyc("trap_mem", S_TRAP, P_T, 1'b0);
                return;
            end
        end
        if (kind == K_MULDIV) begin
            for (int i = 0; i < lat; i++) begin
                noise(); bus.mul_div_done = (i == lat - 1);
                cyc("muldiv", S_MULDIV, (i == 0) ? P_X : P_NONE, 1'b0);
            end
        end
        model_instret = model_instret + 32'd1;
        if (kind == K_WFI) begin
            for (int i = 0; i <= lat; i++) begin
                noise(); bus.interrupt_pending = (i == lat);
                cyc("wb_wfi", S_WB, (i == 0) ? P_W : P_NONE, i > 0);
            end
            noise(); cyc("trap_wake", S_TRAP, P_T, 1'b0);
        end else begin
            noise(); bus.interrupt_pending = irq_after;
            cyc("wb", S_WB, P_W, 1'b0);
            if (irq_after) begin
                noise(); cyc("trap_irq", S_TRAP, P_T, 1'b0);
            end
        end
    endtask

    initial begin
        int kind;
        int lat;
        model_instret = 32'd0;
        noise();
        reset = 1'b1;
        #12;
        chk("rst_state",   32'(bus.state_out), 32'(S_IDLE));
        chk("rst_pulses",  32'(pulses()), 32'(P_NONE));
        chk("rst_sleep",   32'(bus.core_sleep), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Minimal ALU instruction with immediate fetch_done.
        leave_idle();
        run_instr(K_ALU, 0, 1, 1'b0, 1'b0);
        chk("alu_instret", bus.instret, 32'd1);

        // Random instruction stream.
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 5));
            lat  = (kind == K_WFI) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 4));
            run_instr(kind, int'($urandom_range(0, 2)), lat, ($urandom_range(0, 3) == 0),
                      (kind == K_LOAD || kind == K_STORE) && ($urandom_range(0, 3) == 0));
        end

        // Load with 3-cycle memory, load faulting with done, WFI held for 10 cycles.
        run_instr(K_LOAD, 0, 3, 1'b0, 1'b0);
        run_instr(K_LOAD, 0, 2, 1'b0, 1'b1);
        run_instr(K_WFI, 0, 10, 1'b0, 1'b0);

        // Counter wrap from all-ones.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        model_instret = 32'hFFFF_FFFF;
        run_instr(K_ALU, 0, 1, 1'b0, 1'b0);
        chk("wrap_instret", bus.instret, 32'd0);

        // sync_reset while stalled in MULDIV keeps instret.
        noise(); bus.fetch_done = 1'b1; cyc("sr_fetch", S_FETCH, P_F, 1'b0);
        noise(); cyc("sr_decode", S_DECODE, P_D, 1'b0);
        noise(); bus.ctl_LOAD = 1'b0; bus.ctl_STORE = 1'b0; bus.ctl_MUL_DIV_FUNCT3 = 1'b1;
        cyc("sr_exec", S_EXEC, P_E, 1'b0);
        noise(); bus.mul_div_done = 1'b0; cyc("sr_muldiv", S_MULDIV, P_X, 1'b0);
        noise(); bus.sync_reset = 1'b1; cyc("sr_muldiv2", S_MULDIV, P_NONE, 1'b0);
        noise(); bus.start = 1'b0; cyc("sr_idle", S_IDLE, P_NONE, 1'b0);
        noise(); bus.start = 1'b1; cyc("sr_restart", S_IDLE, P_NONE, 1'b0);

        // Async reset while stalled in MEM.
        noise(); bus.fetch_done = 1'b1; cyc("ar_fetch", S_FETCH, P_F, 1'b0);
        noise(); cyc("ar_decode", S_DECODE, P_D, 1'b0);
        noise(); bus.ctl_LOAD = 1'b1; cyc("ar_exec", S_EXEC, P_E, 1'b0);
        noise(); bus.mem_done = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_instret = 32'd0;
        chk("ar_state",   32'(bus.state_out), 32'(S_IDLE));
        chk("ar_pulses",  32'(pulses()), 32'(P_NONE));
        chk("ar_instret", bus.instret, 32'd0);
        for (int i = 0; i < 3; i++) begin
            noise(); bus.start = 1'b1; bus.exception = 1'b1;
            cyc("ar_hold", S_IDLE, P_NONE, 1'b0);
        end
        reset = 1'b0;
        leave_idle();
        run_instr(K_ALU, 1, 1, 1'b0, 1'b0);
        chk("ar_after_instret", bus.instret, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
